frame_config_loader: RTL and testbench
======================================

FRAME_CONFIG_LOADER -- requirements
Module: frame_config_loader

Interface
REQ-001 The block SHALL have parameter FRAME_BITS, default 32, meaning the width of one configuration frame word.
REQ-002 The block SHALL have parameter MAX_FRAMES, default 20, meaning the number of frame strobes per tile column.
REQ-003 The block SHALL have port UserCLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port cfg_data, input, 32 bits: the config word stream.
REQ-006 The block SHALL have port cfg_valid, input, 1 bit: cfg_data valid.
REQ-007 The block SHALL have port cfg_ready, output, 1 bit: a word is accepted on a cycle where cfg_valid and cfg_ready are both 1.
REQ-008 The block SHALL have port FrameData, output, FRAME_BITS bits: the frame word to the column.
REQ-009 The block SHALL have port FrameStrobe, output, MAX_FRAMES bits: a one-hot write strobe.
REQ-010 The block SHALL have port busy, output, 1 bit: a load is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: a one-cycle pulse on load completion.
REQ-012 The block SHALL have port error, output, 1 bit: sticky error flag.

Function
REQ-013 States SHALL be IDLE, LOAD, SETUP, STROBE and ERROR, plus CHECK when FCL_CHECKSUM_EN is defined.
REQ-014 In IDLE, the block SHALL hold cfg_ready=1, and an accepted word SHALL be the header.
- Header fields: [31:24] sync, [12:8] count-1, [4:0] start frame.
REQ-015 A header with sync==8'hFA and start+count<=MAX_FRAMES SHALL load the frame pointer=start and remaining=count, then go to LOAD.
REQ-016 Any other header SHALL go to ERROR and set error=1.
REQ-017 In LOAD, the block SHALL hold cfg_ready=1, and an accepted word SHALL be registered to FrameData[FRAME_BITS-1:0] on the next edge, with the state going to SETUP.
REQ-018 SETUP SHALL last 1 cycle with FrameStrobe=0 and FrameData stable, then go to STROBE.
REQ-019 STROBE SHALL last 1 cycle with FrameStrobe[pointer]=1 and all other strobe bits 0.
- The pointer then increments and remaining decrements.
- If remaining becomes 0, the block goes to IDLE (or CHECK) with done=1 for 1 cycle; otherwise it returns to LOAD.
REQ-020 Latency: a data word accepted at cycle N SHALL appear on FrameData at N+1, strobe at N+2, and cfg_ready SHALL be 1 again at N+3.
REQ-021 cfg_ready SHALL be 0 in SETUP, STROBE and ERROR.
- cfg_valid during those states SHALL be ignored; the word is not consumed.
REQ-022 FrameData SHALL hold its value until the next data word is registered, including after the load ends.
REQ-023 At most one FrameStrobe bit SHALL ever be 1, and strobes SHALL only occur in STROBE.
REQ-024 The pointer SHALL never exceed MAX_FRAMES-1; the header range check guarantees no wrap-around.
REQ-025 busy SHALL be 1 in every state except IDLE and ERROR.
REQ-026 ERROR SHALL be terminal until reset.
- In ERROR, error=1, cfg_ready=0 and FrameStrobe=0.
REQ-027 A count field of 0 SHALL encode 1 frame; a count field of 31 SHALL encode 32 frames, which is legal only if MAX_FRAMES>=32+start.

Reset
REQ-028 Reset SHALL be sampled on the UserCLK edge, and it SHALL take priority over every transition, including mid-STROBE.
REQ-029 After reset the outputs SHALL be:
- state=IDLE, FrameData=0, FrameStrobe=0;
- cfg_ready=1, busy=0, done=0, error=0;
- pointer, remaining and checksum cleared.
REQ-030 A load interrupted by reset SHALL NOT complete, and no strobe SHALL appear on the cycle after reset is asserted.

Configuration
REQ-031 The macro FCL_CHECKSUM_EN SHALL control the trailing checksum check.
- When defined: the block keeps a running XOR of all data words of the load.
- After the last strobe it enters CHECK with cfg_ready=1 and accepts one word.
- If that word equals the XOR, it pulses done and goes to IDLE; otherwise it goes to ERROR.
- done SHALL NOT pulse at the last strobe in this case.
REQ-032 When FCL_CHECKSUM_EN is undefined, the CHECK state and the checksum register SHALL be absent, and done SHALL pulse on the cycle after the last STROBE.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Header 32'hFA00_0003 plus data 32'h1234_5678 -> FrameData=32'h1234_5678; FrameStrobe=20'h00008 for exactly 1 cycle, 2 cycles after acceptance; then done.
- Header 32'hFA00_0210 plus three words A, B, C -> strobes on bits 16, 17, 18 in order, each carrying its matching word; busy=1 throughout.
- Header 32'hFA00_0413 (19+5>20) -> error=1, cfg_ready=0, and no strobe ever occurs; recovery only by reset.
- Bad sync 32'hAB00_0000 -> ERROR.
- cfg_valid held high continuously -> exactly one word accepted per 3 cycles during data.
- Reset asserted in the SETUP cycle -> no strobe occurs, and the next cycle shows all outputs at reset values.
- With FCL_CHECKSUM_EN, header 32'hFA00_0100, words 32'hF0F0_0000 and 32'h0F0F_0000, then checksum 32'hFFFF_0000 -> done; the same load with checksum 32'h0 -> error.

Source files
------------

// File: rtl/frame_config_loader.sv
`default_nettype none
// frame_config_loader: header-driven loader that writes config words into a tile column, one strobe per word.
// Define FCL_CHECKSUM_EN to require a trailing XOR checksum word before done is signalled.
module frame_config_loader #(
  parameter int FRAME_BITS = 32,
  parameter int MAX_FRAMES = 20
) (
  input  logic                  UserCLK,
  input  logic                  reset,
  input  logic [31:0]           cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic [FRAME_BITS-1:0] FrameData,
  output logic [MAX_FRAMES-1:0] FrameStrobe,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int                  PTR_W        = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
  localparam logic [6:0]          FRAMES_LIMIT = 7'((MAX_FRAMES > 127) ? 127 : MAX_FRAMES);
  localparam logic [MAX_FRAMES-1:0] STROBE_ONE = MAX_FRAMES'(1);
  localparam logic [7:0]          SYNC_WORD    = 8'hFA;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETUP  = 3'd2,
    STROBE = 3'd3,
    ERROR  = 3'd4
`ifdef FCL_CHECKSUM_EN
    , CHECK = 3'd5
`endif
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] pointer;
  logic [5:0]       remaining;
`ifdef FCL_CHECKSUM_EN
  logic [31:0]      checksum;
`endif

  logic       accept;
  logic [5:0] hdr_count;
  logic [6:0] hdr_end;
  logic       hdr_ok;
  logic       unused_hdr_bits;

  assign accept    = cfg_valid & cfg_ready;
  assign hdr_count = {1'b0, cfg_data[12:8]} + 6'd1;
  assign hdr_end   = {2'b00, cfg_data[4:0]} + {1'b0, hdr_count};
  // Range check up front guarantees the pointer never walks past the last frame.
  assign hdr_ok    = (cfg_data[31:24] == SYNC_WORD) && (hdr_end <= FRAMES_LIMIT);
  assign unused_hdr_bits = ^{cfg_data[23:13], cfg_data[7:5]};

  always_ff @(posedge UserCLK) begin
    if (reset) begin
      state       <= IDLE;
      FrameData   <= '0;
      FrameStrobe <= '0;
      cfg_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      pointer     <= '0;
      remaining   <= '0;
`ifdef FCL_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else begin
      done        <= 1'b0;
      FrameStrobe <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (hdr_ok) begin
              pointer   <= PTR_W'(cfg_data[4:0]);
              remaining <= hdr_count;
              busy      <= 1'b1;
              state     <= LOAD;
`ifdef FCL_CHECKSUM_EN
              checksum  <= '0;
`endif
            end else begin
              error     <= 1'b1;
              cfg_ready <= 1'b0;
              state     <= ERROR;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            FrameData <= FRAME_BITS'(cfg_data);
            cfg_ready <= 1'b0;
            state     <= SETUP;
`ifdef FCL_CHECKSUM_EN
            checksum  <= checksum ^ cfg_data;
`endif
          end
        end
        SETUP: begin
          FrameStrobe <= STROBE_ONE << pointer;
          state       <= STROBE;
        end
        STROBE: begin
          remaining <= remaining - 6'd1;
          cfg_ready <= 1'b1;
          if (remaining == 6'd1) begin
`ifdef FCL_CHECKSUM_EN
            state <= CHECK;
`else
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
`endif
          end else begin
            pointer <= pointer + PTR_W'(1);
            state   <= LOAD;
          end
        end
`ifdef FCL_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            busy <= 1'b0;
            if (cfg_data == checksum) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              error     <= 1'b1;
              cfg_ready <= 1'b0;
              state     <= ERROR;
            end
          end
        end
`endif
        ERROR: begin
          error     <= 1'b1;
          cfg_ready <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          cfg_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_config_loader.sv
`default_nettype none
// Bench for frame_config_loader: directed and randomized loads checked against a transaction-level model.
module tb_frame_config_loader;
  localparam int FRAME_BITS = 32;
  localparam int MAX_FRAMES = 20;
  localparam int NREC       = 16384;
`ifdef FCL_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif

  logic                  UserCLK = 1'b0;
  logic                  reset;
  logic [31:0]           cfg_data;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [FRAME_BITS-1:0] FrameData;
  logic [MAX_FRAMES-1:0] FrameStrobe;
  logic                  busy;
  logic                  done;
  logic                  error;

  frame_config_loader #(.FRAME_BITS(FRAME_BITS), .MAX_FRAMES(MAX_FRAMES)) dut (
    .UserCLK(UserCLK), .reset(reset), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
    .busy(busy), .done(done), .error(error)
  );

  always #5 UserCLK = ~UserCLK;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Per-cycle trace of outputs, indexed by cycle number.
  logic [31:0]           rec_data   [NREC];
  logic [MAX_FRAMES-1:0] rec_strobe [NREC];
  logic                  rec_ready  [NREC];
  logic                  rec_busy   [NREC];
  logic                  rec_done   [NREC];
  logic                  rec_err    [NREC];
  logic                  rec_acc    [NREC];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic cycle(input logic v, input logic [31:0] d, input logic r, output logic acc);
    @(negedge UserCLK);
    acc = v && cfg_ready && !r;
    if (cyc < NREC) begin
      rec_data[cyc]   = FrameData;
      rec_strobe[cyc] = FrameStrobe;
      rec_ready[cyc]  = cfg_ready;
      rec_busy[cyc]   = busy;
      rec_done[cyc]   = done;
      rec_err[cyc]    = error;
      rec_acc[cyc]    = acc;
    end
    cyc++;
    cfg_valid = v;
    cfg_data  = d;
    reset     = r;
  endtask

  task automatic do_reset();
    logic acc;
    cycle(1'b0, 32'h0, 1'b1, acc);
    cycle(1'b0, 32'h0, 1'b1, acc);
    cycle(1'b0, 32'h0, 1'b0, acc);
  endtask

  function automatic bit hdr_legal(input logic [31:0] h);
    int start, cnt;
    start = int'(h[4:0]);
    cnt   = int'(h[12:8]) + 1;
    return (h[31:24] == 8'hFA) && (start + cnt <= MAX_FRAMES);
  endfunction

  task automatic run_load(input logic [31:0] words[$], input bit hold, input int junk,
                          output int s, output int e);
    logic [31:0] q[$];
    logic acc, v;
    int budget;
    q = words;
    s = cyc;
    budget = 0;
    while (q.size() > 0 && budget < 400) begin
      v = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
      cycle(v, v ? q[0] : $urandom(), 1'b0, acc);
      if (acc) void'(q.pop_front());
      budget++;
    end
    if (q.size() != 0) check_eq("load_timeout", q.size(), 0);
    repeat (junk) cycle(1'b1, $urandom(), 1'b0, acc);
    repeat (6) cycle(1'b0, $urandom(), 1'b0, acc);
    e = cyc;
  endtask

  // Model: derive every expected event from the header fields and the accept times.
  task automatic analyze(input logic [31:0] words[$], input bit hold, input int s, input int e,
                         output bit need_reset);
    int acc_idx[$];
    int start, cnt, h, n, last, done_cyc, n_strobes, n_done, n_multi, n_idle_busy;
    logic [31:0] hdr, x;
    logic [MAX_FRAMES-1:0] oh;
    bit legal, csum_ok;
    hdr   = words[0];
    start = int'(hdr[4:0]);
    cnt   = int'(hdr[12:8]) + 1;
    legal = hdr_legal(hdr);
    need_reset = 1'b0;
    n_strobes = 0; n_done = 0; n_multi = 0;
    for (int c = s; c < e; c++) begin
      if (rec_acc[c]) acc_idx.push_back(c);
      if (rec_strobe[c] != '0) n_strobes++;
      if ($countones(rec_strobe[c]) > 1) n_multi++;
      if (rec_done[c]) n_done++;
    end
    check_eq("strobe_onehot", n_multi, 0);
    if (acc_idx.size() == 0) begin
      check_eq("hdr_accepted", 0, 1);
      need_reset = 1'b1;
      return;
    end
    h = acc_idx[0];
    if (!legal) begin
      need_reset = 1'b1;
      check_eq("err_accepts", acc_idx.size(), 1);
      check_eq("err_flag", rec_err[h+1], 1);
      check_eq("err_ready", rec_ready[h+1], 0);
      check_eq("err_busy", rec_busy[h+1], 0);
      check_eq("err_flag_end", rec_err[e-1], 1);
      check_eq("err_ready_end", rec_ready[e-1], 0);
      check_eq("err_strobes", n_strobes, 0);
      check_eq("err_done", n_done, 0);
      return;
    end
    check_eq("accepts", acc_idx.size(), 1 + cnt + CSUM);
    if (acc_idx.size() != 1 + cnt + CSUM) begin
      need_reset = 1'b1;
      return;
    end
    check_eq("busy_after_hdr", rec_busy[h+1], 1);
    x = 32'h0;
    for (int k = 0; k < cnt; k++) begin
      n = acc_idx[k+1];
      x = x ^ words[k+1];
      oh = '0;
      oh[start+k] = 1'b1;
      check_eq("data_n1", rec_data[n+1], words[k+1]);
      check_eq("strobe_n1", rec_strobe[n+1], 0);
      check_eq("ready_n1", rec_ready[n+1], 0);
      check_eq("strobe_n2", rec_strobe[n+2], oh);
      check_eq("data_n2", rec_data[n+2], words[k+1]);
      check_eq("ready_n2", rec_ready[n+2], 0);
      check_eq("ready_n3", rec_ready[n+3], 1);
      if (hold && k > 0) check_eq("word_gap", n - acc_idx[k], 3);
    end
    check_eq("strobe_count", n_strobes, cnt);
    last = acc_idx[cnt] + 2;
    csum_ok = 1'b1;
    done_cyc = last + 1;
    if (CSUM == 1) begin
      n = acc_idx[cnt+1];
      csum_ok = (words[cnt+1] == x);
      done_cyc = n + 1;
      check_eq("csum_no_early_done", rec_done[last+1], 0);
    end
    n_idle_busy = 0;
    for (int c = h + 1; c < done_cyc; c++) if (!rec_busy[c]) n_idle_busy++;
    check_eq("busy_throughout", n_idle_busy, 0);
    if (csum_ok) begin
      check_eq("done_pulse", rec_done[done_cyc], 1);
      check_eq("done_count", n_done, 1);
      check_eq("busy_after_done", rec_busy[done_cyc], 0);
      check_eq("ready_after_done", rec_ready[done_cyc], 1);
      check_eq("error_clear", rec_err[e-1], 0);
    end else begin
      need_reset = 1'b1;
      check_eq("csum_err_flag", rec_err[done_cyc], 1);
      check_eq("csum_err_ready", rec_ready[done_cyc], 0);
      check_eq("csum_no_done", n_done, 0);
    end
    check_eq("data_hold_end", rec_data[e-1], words[cnt]);
  endtask

  task automatic load_and_check(input logic [31:0] words[$], input bit hold, input logic [31:0] csum_mask);
    logic [31:0] w[$];
    logic [31:0] x;
    int s, e, cnt;
    bit nr, legal;
    w = words;
    legal = hdr_legal(w[0]);
    if (CSUM == 1 && legal) begin
      cnt = int'(w[0][12:8]) + 1;
      x = 32'h0;
      for (int k = 1; k <= cnt; k++) x = x ^ w[k];
      w.push_back(x ^ csum_mask);
    end
    if (!legal) w = '{words[0]};
    run_load(w, hold, legal ? 0 : 6, s, e);
    analyze(w, hold, s, e, nr);
    if (nr) do_reset();
  endtask

  initial begin
    logic acc;
    logic [31:0] w[$];
    logic [31:0] hdr;
    int start, cnt, n_bad, s0;
    reset = 1'b1;
    cfg_valid = 1'b0;
    cfg_data = 32'h0;
    do_reset();
    check_eq("rst_data", rec_data[cyc-1], 0);
    check_eq("rst_strobe", rec_strobe[cyc-1], 0);
    check_eq("rst_ready", rec_ready[cyc-1], 1);
    check_eq("rst_busy", rec_busy[cyc-1], 0);
    check_eq("rst_done", rec_done[cyc-1], 0);
    check_eq("rst_error", rec_err[cyc-1], 0);

    w = '{32'hFA00_0003, 32'h1234_5678};
    load_and_check(w, 1'b0, 32'h0);
    w = '{32'hFA00_0210, $urandom(), $urandom(), $urandom()};
    load_and_check(w, 1'b0, 32'h0);
    w = '{32'hFA00_0413};
    load_and_check(w, 1'b0, 32'h0);
    w = '{32'hAB00_0000};
    load_and_check(w, 1'b0, 32'h0);
    w = '{32'hFA00_0504, $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    load_and_check(w, 1'b1, 32'h0);
`ifdef FCL_CHECKSUM_EN
    w = '{32'hFA00_0100, 32'hF0F0_0000, 32'h0F0F_0000};
    load_and_check(w, 1'b0, 32'h0);
    load_and_check(w, 1'b0, 32'hFFFF_0000);
`endif

    for (int it = 0; it < 30; it++) begin
      start = $urandom_range(0, MAX_FRAMES - 1);
      cnt   = $urandom_range(1, MAX_FRAMES - start);
      hdr   = $urandom();
      hdr[31:24] = 8'hFA;
      hdr[12:8]  = 5'(cnt - 1);
      hdr[4:0]   = 5'(start);
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) hdr[31:24] = 8'hFA ^ 8'($urandom_range(1, 255));
        else hdr[12:8] = 5'(MAX_FRAMES - start);
      end
      w = '{hdr};
      for (int k = 0; k < cnt; k++) w.push_back($urandom());
      load_and_check(w, $urandom_range(0, 1) == 1,
                     (CSUM == 1 && $urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 32'hFFFF)) : 32'h0);
    end

    // Reset landing in the SETUP cycle must cancel the pending strobe.
    cycle(1'b1, 32'hFA00_0003, 1'b0, acc);
    check_eq("rst_mid_hdr_acc", acc, 1);
    cycle(1'b1, 32'hCAFE_F00D, 1'b0, acc);
    check_eq("rst_mid_data_acc", acc, 1);
    cycle(1'b0, 32'h0, 1'b1, acc);
    check_eq("rst_mid_setup_data", rec_data[cyc-1], 32'hCAFE_F00D);
    check_eq("rst_mid_setup_strobe", rec_strobe[cyc-1], 0);
    cycle(1'b0, 32'h0, 1'b0, acc);
    check_eq("rst_mid_strobe", rec_strobe[cyc-1], 0);
    check_eq("rst_mid_data", rec_data[cyc-1], 0);
    check_eq("rst_mid_ready", rec_ready[cyc-1], 1);
    check_eq("rst_mid_busy", rec_busy[cyc-1], 0);
    check_eq("rst_mid_done", rec_done[cyc-1], 0);
    check_eq("rst_mid_error", rec_err[cyc-1], 0);
    s0 = cyc;
    repeat (5) cycle(1'b0, 32'h0, 1'b0, acc);
    n_bad = 0;
    for (int c = s0; c < cyc; c++) if (rec_strobe[c] != '0 || rec_done[c]) n_bad++;
    check_eq("rst_mid_quiet", n_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
